// File: rtl/switch_arbiter_pkg.sv
// Shared router definitions: arbiter state encoding and pointer wrap helper.
package switch_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Explicit compare so non-power-of-2 port counts wrap correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/switch_arbiter_if.sv
// Request/grant bundle between input ports and the output arbiter.
interface switch_arbiter_if import switch_arbiter_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_BITS   = $clog2(NUM_INPUTS)
) ();

  // req[i] offers one flit from input i; a flit moves only on a cycle where the
  // arbiter sees req[i] and out_ready together, reported one cycle later as grant[i].
  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] tail;
  logic                  out_ready;
  logic [NUM_INPUTS-1:0] grant;
  logic                  grant_valid;
  logic [NUM_BITS-1:0]   grant_index;
  logic                  locked;
  arb_state_t            dbg_state;
  logic [NUM_BITS-1:0]   dbg_ptr;

  modport master (
    output req, tail, out_ready,
    input  grant, grant_valid, grant_index, locked, dbg_state, dbg_ptr
  );

  modport slave (
    input  req, tail, out_ready,
    output grant, grant_valid, grant_index, locked, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/switch_arbiter_priority_encoder.sv
// Lowest-index-first priority encoder with a found flag.
module priority_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// Round-robin output arbiter that holds the output for a whole packet once granted.
module switch_arbiter import switch_arbiter_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_BITS   = $clog2(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             reset_n,
  switch_arbiter_if.slave  bus
);

  arb_state_t            r_state;
  logic [NUM_BITS-1:0]   r_ptr;
  logic [NUM_BITS-1:0]   r_owner;
  logic [NUM_INPUTS-1:0] r_grant;
  logic                  r_grant_valid;
  logic [NUM_BITS-1:0]   r_grant_index;
  logic                  r_locked;

  logic [NUM_INPUTS-1:0] w_mask;
  logic [NUM_INPUTS-1:0] w_masked_req;
  logic [NUM_BITS-1:0]   w_masked_idx;
  logic [NUM_BITS-1:0]   w_plain_idx;
  logic                  w_masked_found;
  logic                  w_any;
  logic [NUM_BITS-1:0]   w_win;

  function automatic logic [NUM_INPUTS-1:0] onehot(input logic [NUM_BITS-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic [NUM_BITS-1:0] next_ptr(input logic [NUM_BITS-1:0] idx);
    return NUM_BITS'(wrap_inc(int'(idx), NUM_INPUTS));
  endfunction

  // Inputs at or above the pointer get first chance; the plain search covers the wrap.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_mask[i] = (NUM_BITS'(i) >= r_ptr);
    end
  end

  assign w_masked_req = bus.req & w_mask;

  priority_encoder #(.N(NUM_INPUTS), .W(NUM_BITS)) u_pe_masked (
    .i_req   (w_masked_req),
    .o_idx   (w_masked_idx),
    .o_found (w_masked_found)
  );

  priority_encoder #(.N(NUM_INPUTS), .W(NUM_BITS)) u_pe_plain (
    .i_req   (bus.req),
    .o_idx   (w_plain_idx),
    .o_found (w_any)
  );

  assign w_win = w_masked_found ? w_masked_idx : w_plain_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ARB_IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
      r_locked      <= 1'b0;
    end else begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (bus.out_ready && w_any) begin
            r_grant       <= onehot(w_win);
            r_grant_valid <= 1'b1;
            r_grant_index <= w_win;
            if (bus.tail[w_win]) begin
              r_ptr <= next_ptr(w_win);
            end else begin
              r_state  <= ARB_LOCKED;
              r_owner  <= w_win;
              r_locked <= 1'b1;
            end
          end
        end
        ARB_LOCKED: begin
          // Only the owner may move flits until its tail goes through.
          if (bus.out_ready && bus.req[r_owner]) begin
            r_grant       <= onehot(r_owner);
            r_grant_valid <= 1'b1;
            r_grant_index <= r_owner;
            if (bus.tail[r_owner]) begin
              r_state  <= ARB_IDLE;
              r_locked <= 1'b0;
              r_ptr    <= next_ptr(r_owner);
            end
          end
        end
        default: begin
          r_state  <= ARB_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_index = r_grant_index;
  assign bus.locked      = r_locked;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_ptr     = r_ptr;

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: driver pushes per-cycle expectations, monitor checks them.
module tb_switch_arbiter;
  import switch_arbiter_pkg::*;

  localparam int N = 4;
  localparam int B = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  switch_arbiter_if #(.NUM_INPUTS(N), .NUM_BITS(B)) bus ();

  switch_arbiter #(.NUM_INPUTS(N), .NUM_BITS(B)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Entry layout: {valid, grant[3:0], grant_index[1:0], locked, ptr[1:0]}
  logic [9:0]   exp_q[$];
  logic [B-1:0] exp_last_idx = '0;
  logic [9:0]   mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle; expected outputs are those registered on the following edge.
  task automatic cycle(input logic [3:0] rq, input logic [3:0] tl, input logic rdy,
                       input logic v, input logic [1:0] idx, input logic lk,
                       input logic [1:0] p);
    logic [3:0] g;
    @(negedge clk);
    #1;
    bus.req       = rq;
    bus.tail      = tl;
    bus.out_ready = rdy;
    if (v) begin
      g            = 4'b0001 << idx;
      exp_last_idx = idx;
    end else begin
      g = 4'b0000;
    end
    exp_q.push_back({v, g, exp_last_idx, lk, p});
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},       32'(bus.grant), 32'd0);
    check({tag, "_grant_valid"}, 32'(bus.grant_valid), 32'd0);
    check({tag, "_grant_index"}, 32'(bus.grant_index), 32'd0);
    check({tag, "_locked"},      32'(bus.locked), 32'd0);
    check({tag, "_ptr"},         32'(bus.dbg_ptr), 32'd0);
    check({tag, "_state"},       32'(bus.dbg_state), 32'(ARB_IDLE));
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("grant_valid_vs_grant", 32'(bus.grant_valid), 32'(|bus.grant));
      check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("grant_valid", 32'(bus.grant_valid), 32'(mon_e[9]));
        check("grant",       32'(bus.grant),       32'(mon_e[8:5]));
        check("grant_index", 32'(bus.grant_index), 32'(mon_e[4:3]));
        check("locked",      32'(bus.locked),      32'(mon_e[2]));
        check("ptr",         32'(bus.dbg_ptr),     32'(mon_e[1:0]));
        check("state",       32'(bus.dbg_state),   32'(mon_e[2] ? ARB_LOCKED : ARB_IDLE));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req       = '0;
    bus.tail      = '0;
    bus.out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Round robin over four single-flit requesters.
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1);
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, 2'd2);
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0, 2'd3);
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);

    // Move ptr to 2, then wrap to input 0 and continue to 1.
    cycle(4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 2'd2);
    cycle(4'b0011, 4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1);
    cycle(4'b0011, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b0, 2'd2);

    // Input 1 sends a 3-flit packet while everyone requests.
    cycle(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1);
    cycle(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
    cycle(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
    cycle(4'b1111, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 2'd2);
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0, 2'd3);

    // Owner 3 stalls; input 0 must not sneak in.
    cycle(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3);
    cycle(4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3);
    cycle(4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3);
    cycle(4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);

    // Downstream back-pressure with ptr=1.
    cycle(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1);
    cycle(4'b0101, 4'b0101, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1);
    cycle(4'b0101, 4'b0101, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1);
    cycle(4'b0101, 4'b0101, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1);
    cycle(4'b0101, 4'b0101, 1'b1, 1'b1, 2'd2, 1'b0, 2'd3);

    // Lock on input 1, then reset mid-packet.
    cycle(4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_last_idx  = '0;
    bus.req       = '0;
    bus.tail      = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/switch_arbiter.md
SWITCH_ARBITER -- requirements
Module: switch_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of requesting input ports (>=2).
REQ-002 SHALL have parameter NUM_BITS, default $clog2(NUM_INPUTS), width of the grant index.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  NUM_INPUTS  per-input flit-ready request.
REQ-006 SHALL have port tail  input  NUM_INPUTS  per-input flag: the presented flit is a packet tail.
REQ-007 SHALL have port out_ready  input  1  downstream can accept one flit this cycle.
REQ-008 SHALL have port grant  output  NUM_INPUTS  registered one-hot grant; all-zero when no transfer.
REQ-009 SHALL have port grant_valid  output  1  registered; high when grant is non-zero.
REQ-010 SHALL have port grant_index  output  NUM_BITS  registered binary index of the granted input.
REQ-011 SHALL have port locked  output  1  high while a multi-flit packet holds the output.

Function
REQ-012 SHALL have two states: IDLE (output free) and LOCKED (output owned by input owner).
REQ-013 SHALL hold a round-robin pointer ptr (NUM_BITS wide) naming the highest-priority input.
REQ-014 In IDLE with out_ready=1 and req!=0, SHALL select winner w = first set req bit at index ptr, ptr+1, ... wrapping NUM_INPUTS-1 -> 0.
REQ-015 Winner selection SHALL use a masked request (bits >= ptr) first, falling back to unmasked req when the masked vector is zero.
REQ-016 On that edge SHALL register grant=onehot(w), grant_valid=1, grant_index=w (latency: 1 cycle from req to grant outputs).
REQ-017 If tail[w]=1 at selection, SHALL stay IDLE and set ptr = (w+1) mod NUM_INPUTS.
REQ-018 If tail[w]=0 at selection, SHALL enter LOCKED with owner=w; ptr unchanged.
REQ-019 In LOCKED SHALL consider only req[owner]; other requests ignored regardless of priority.
REQ-020 In LOCKED with req[owner]=1 and out_ready=1, SHALL grant owner; if tail[owner]=1 SHALL return to IDLE and set ptr=(owner+1) mod NUM_INPUTS.
REQ-021 In LOCKED with req[owner]=0 or out_ready=0, SHALL register grant=0, grant_valid=0, stay LOCKED; grant_index holds last value.
REQ-022 In IDLE with out_ready=0 or req=0, SHALL register grant=0, grant_valid=0; ptr and state unchanged.
REQ-023 Single-flit packet (head and tail same flit) SHALL follow REQ-017; never enters LOCKED.
REQ-024 locked SHALL equal (state==LOCKED), registered.
REQ-025 grant SHALL never have more than one bit set; grant_valid SHALL equal |grant.
REQ-026 Non-power-of-2 NUM_INPUTS: ptr wrap SHALL be explicit compare to NUM_INPUTS-1, not natural overflow.

Reset
REQ-027 On reset_n=0, asynchronously: state=IDLE, ptr=0, owner=0, grant=0, grant_valid=0, grant_index=0, locked=0.
REQ-028 Reset asserted mid-packet SHALL drop the lock; first edge after release arbitrates from ptr=0.

Structure
REQ-029 Arbiter state enum (IDLE, LOCKED) SHALL live in the shared router package.
REQ-030 SHALL instantiate priority_encoder twice (masked and unmasked request) for winner index; no other sub-modules.
REQ-031 Expected size 120-250 lines RTL.

Verification
REQ-032 Reset then req=4'b1111, tail=4'b1111, out_ready=1 for 4 cycles -> grant_index 0,1,2,3 in order, one cycle after each request edge.
REQ-033 ptr=2, req=4'b0011, tail=4'b0011 -> wrap: grant_index=0, then ptr=1, next grant_index=1.
REQ-034 Input 1 sends 3-flit packet (tail only on flit 3) with req=4'b1111 -> grant_index=1 for 3 grants, locked=1 until tail granted, then grant_index=2.
REQ-035 LOCKED owner=3, req[3]=0 for 2 cycles, req[0]=1 -> grant=0, locked=1 both cycles, no grant to input 0.
REQ-036 out_ready=0 for 3 cycles with req=4'b0101 -> grant_valid=0, ptr unchanged; on out_ready=1 grant_index = first set bit from ptr.
REQ-037 reset_n pulsed low mid-packet (locked=1) -> outputs zero immediately, locked=0, next arbitration starts at input 0.
